// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for CPU data accesses.
// A request is accepted with a valid/ready handshake. After WAIT_CYCLES wait
// states the access executes against a word-addressed array. The result is
// then held on a valid/ready response channel until the initiator takes it.
// Misaligned or out-of-range accesses are not performed; they are reported
// through rsp_err_o instead.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             err_s;
  logic             mem_we_s;
  logic [31:0]      mem_rdata_s;

  // Decode the latched address: the word index, plus an error flag for a misaligned or out-of-range access.
  always_comb begin
    idx_s       = addr_q[IDX_W+1:2];
    err_s       = (addr_q[1:0] != 2'b00) ||
                  ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    mem_rdata_s = mem_q[idx_s];
  end

  // Compute the next state, the request latch contents and the response outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_EXEC;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_EXEC: begin
        // Writes commit here, so a reset that arrives earlier drops the write.
        mem_we_s    = we_q && !err_s;
        rdata_d     = (we_q || err_s) ? 32'd0 : mem_rdata_s;
        err_d       = err_s;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 4'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Register the FSM state, the latched request and the response outputs; reset is asynchronous.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage array; its contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance A uses WAIT_CYCLES=2 and
// instance B uses WAIT_CYCLES=0. Drivers push expected responses into queues.
// Monitors pop those entries and compare them whenever a response is presented.
module tb_data_mem_responder;

  logic clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_we, a_rsp_valid, a_rsp_ready, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req_valid, b_req_ready, b_we, b_rsp_valid, b_rsp_ready, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rdata), .rsp_err_o(a_err)
  );

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   acc_a[$];
  int   acc_b[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   a_seen = 1'b0;
  bit   b_seen = 1'b0;
  int   b_last_acc = -1;
  int   lat_a;
  int   lat_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so that latency can be measured in edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor for A: record accepts; compare every presented response with the queue head.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      acc_a.delete();
      a_seen = 1'b0;
    end else begin
      if (a_req_valid && a_req_ready) acc_a.push_back(cyc + 1);
      if (a_rsp_valid) begin
        chk("a_req_ready_during_resp", {31'd0, a_req_ready}, 32'd0);
        if (qa.size() == 0) begin
          fail_now("a_unexpected_response");
        end else begin
          chk("a_rdata", a_rdata, qa[0].rdata);
          chk("a_err", {31'd0, a_err}, {31'd0, qa[0].err});
          if (!a_seen) begin
            a_seen = 1'b1;
            if (acc_a.size() == 0) begin
              fail_now("a_response_without_accept");
            end else begin
              lat_a = cyc - acc_a.pop_front();
              chk("a_latency", 32'(lat_a), 32'd3);
            end
          end
          if (a_rsp_ready) begin
            void'(qa.pop_front());
            a_seen = 1'b0;
          end
        end
      end
    end
  end

  // Monitor for B: same scoreboard, plus a check of accept-to-accept spacing.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      acc_b.delete();
      b_seen = 1'b0;
    end else begin
      if (b_req_valid && b_req_ready) begin
        if (b_last_acc >= 0) chk("b_accept_spacing", 32'(cyc + 1 - b_last_acc), 32'd3);
        b_last_acc = cyc + 1;
        acc_b.push_back(cyc + 1);
      end
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          fail_now("b_unexpected_response");
        end else begin
          chk("b_rdata", b_rdata, qb[0].rdata);
          chk("b_err", {31'd0, b_err}, {31'd0, qb[0].err});
          if (!b_seen) begin
            b_seen = 1'b1;
            if (acc_b.size() == 0) begin
              fail_now("b_response_without_accept");
            end else begin
              lat_b = cyc - acc_b.pop_front();
              chk("b_latency", 32'(lat_b), 32'd1);
            end
          end
          if (b_rsp_ready) begin
            void'(qb.pop_front());
            b_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_a_accept();
    int n;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) fail_now("a_accept_timeout");
  endtask

  task automatic wait_a_drain();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0) begin
      fail_now("a_response_timeout");
      qa.delete();
    end
  endtask

  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    qa.push_back(e);
    a_we        = we;
    a_addr      = addr;
    a_wdata     = wd;
    a_req_valid = 1'b1;
    wait_a_accept();
    @(negedge clk);
    // Scramble the request inputs mid-transaction; the responder must ignore them.
    a_req_valid = 1'b0;
    a_we        = ~we;
    a_addr      = 32'hFFFF_FFF0;
    a_wdata     = 32'h5A5A_5A5A;
    wait_a_drain();
  endtask

  logic        bv_we   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] bv_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
  logic [31:0] bv_wd   [6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h0, 32'h0, 32'h0};
  logic [31:0] bv_exp  [6] = '{32'h0, 32'h0, 32'h0, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

  // Bound the whole run so that it cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_a_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("reset_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("reset_a_rdata", a_rdata, 32'd0);
    chk("reset_a_err", {31'd0, a_err}, 32'd0);
    chk("reset_b_req_ready", {31'd0, b_req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write followed by read of the same word, three edges of latency each.
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Address errors must not disturb stored words; 0x200 would alias word 0 if truncated.
    txn_a(1'b1, 32'h0, 32'hA5A5_0000, 32'h0, 1'b0);
    txn_a(1'b1, 32'h80, 32'h0808_0808, 32'h0, 1'b0);
    txn_a(1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    txn_a(1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    txn_a(1'b1, 32'h200, 32'h0BAD_0BAD, 32'h0, 1'b1);
    txn_a(1'b1, 32'h12, 32'h1111_1111, 32'h0, 1'b1);
    txn_a(1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0);
    txn_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn_a(1'b0, 32'h80, 32'h0, 32'h0808_0808, 1'b0);
    txn_a(1'b1, 32'h1FC, 32'h7777_1FC0, 32'h0, 1'b0);
    txn_a(1'b0, 32'h1FC, 32'h0, 32'h7777_1FC0, 1'b0);

    // Stall the response for 5 cycles while a new request is held pending.
    a_rsp_ready = 1'b0;
    e.rdata = 32'hDEAD_BEEF;
    e.err   = 1'b0;
    qa.push_back(e);
    a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'h0; a_req_valid = 1'b1;
    wait_a_accept();
    @(negedge clk);
    a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hBAD0_BAD0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!a_rsp_valid) fail_now("a_stall_response_timeout");
    repeat (5) @(negedge clk);
    a_req_valid = 1'b0;
    chk("a_no_accept_during_resp", 32'(acc_a.size()), 32'd0);
    a_rsp_ready = 1'b1;
    wait_a_drain();
    txn_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Zero wait states, with valid and ready held high: one transaction every three cycles.
    for (int i = 0; i < 6; i++) begin
      e.rdata = bv_exp[i];
      e.err   = 1'b0;
      qb.push_back(e);
      b_we = bv_we[i]; b_addr = bv_addr[i]; b_wdata = bv_wd[i]; b_req_valid = 1'b1;
      n = 0;
      while (!b_req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!b_req_ready) fail_now("b_accept_timeout");
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qb.size() != 0) fail_now("b_response_timeout");

    // Two back-to-back writes to the same word; the later write must win.
    txn_a(1'b1, 32'h7C, 32'h0000_0001, 32'h0, 1'b0);
    txn_a(1'b1, 32'h7C, 32'h0000_0002, 32'h0, 1'b0);
    txn_a(1'b0, 32'h7C, 32'h0, 32'h0000_0002, 1'b0);

    // Reset during WAIT drops the write; the read leaves non-zero rdata behind first.
    txn_a(1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
    txn_a(1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);
    a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678; a_req_valid = 1'b1;
    wait_a_accept();
    @(negedge clk);
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_a_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("midreset_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("midreset_a_rdata", a_rdata, 32'd0);
    chk("midreset_a_err", {31'd0, a_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn_a(1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
